tg_image_sender: RTL and testbench



---
 rtl/tg_sender_pkg.sv | 40 ++++
 rtl/tg_tx_handshake.sv | 54 +++++
 rtl/tg_image_sender.sv | 197 +++++++++++++++++++
 tb/tb_tg_image_sender.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tg_sender_pkg.sv
// Shared state encodings, protocol characters and ASCII-hex helpers for the
// visor target-load sender.
package tg_sender_pkg;

  localparam logic [7:0] CH_LOAD = 8'h4C;
  localparam logic [7:0] CH_WORD = 8'h3D;
  localparam logic [7:0] CH_EOL  = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_L,
    S_SEND_LEN_LO,
    S_SEND_LEN_HI,
    S_WAIT_EQ,
    S_SEND_LO,
    S_SEND_HI,
    S_SKIP_LINE
  } main_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_ACK
  } txh_state_e;

  function automatic logic is_send_state(input main_state_e s);
    return (s == S_SEND_LEN_LO) || (s == S_SEND_LEN_HI) ||
           (s == S_SEND_LO)     || (s == S_SEND_HI);
  endfunction

  // Lower-case hex only: the visor echoes words as 0-9 / a-f.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
  endfunction

endpackage

// File: rtl/tg_tx_handshake.sv
// Four-phase load/busy handshake toward the UART transmitter; byte_done_o
// pulses once the transmitter has taken the byte and returned to idle.
module tg_tx_handshake (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_req_i,
  input  logic [7:0] byte_dat_i,
  output logic       byte_done_o,
  output logic [7:0] tx_data_o,
  output logic       tx_load_o,
  input  logic       tx_busy_i
);
  import tg_sender_pkg::*;

  txh_state_e state_q, state_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= T_IDLE;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A transmitter still busy from elsewhere holds the request in T_IDLE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      T_IDLE: begin
        if (byte_req_i && !tx_busy_i) begin
          state_d = T_REQ;
          data_d  = byte_dat_i;
        end
      end
      T_REQ: begin
        if (tx_busy_i) state_d = T_ACK;
      end
      T_ACK: begin
        if (!tx_busy_i) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Kept out of the next-state block so the request path stays acyclic.
  assign byte_done_o = (state_q == T_ACK) && !tx_busy_i;
  assign tx_load_o   = (state_q == T_REQ);
  assign tx_data_o   = data_q;

endmodule

// File: rtl/tg_image_sender.sv
// Host side of the visor UART target-load protocol: streams an image from a ROM,
// paced by visor prompts. TG_SENDER_ECHO_CHECK_EN adds echo-line verification.
module tg_image_sender
  import tg_sender_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] PROMPT_LOAD = CH_LOAD,
  parameter logic [7:0] PROMPT_WORD = CH_WORD,
  parameter logic [7:0] EOL_CHAR    = CH_EOL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [15:0]       img_data,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  main_state_e       state_q, state_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wreg_q, wreg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              echo_ok;

  logic              byte_req;
  logic [7:0]        byte_dat;
  logic              byte_done;

`ifdef TG_SENDER_ECHO_CHECK_EN
  logic [1:0]        eq_cnt_q, eq_cnt_d;
  logic [2:0]        ndig_q, ndig_d;
  logic [15:0]       echo_q, echo_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eq_cnt_q <= 2'd0;
      ndig_q   <= 3'd0;
      echo_q   <= 16'h0000;
    end else begin
      eq_cnt_q <= eq_cnt_d;
      ndig_q   <= ndig_d;
      echo_q   <= echo_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 16'h0000;
      addr_q  <= '0;
      wreg_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wreg_q  <= wreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wreg_d  = wreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef TG_SENDER_ECHO_CHECK_EN
    eq_cnt_d = eq_cnt_q;
    ndig_d   = ndig_q;
    echo_d   = echo_q;
    echo_ok  = (ndig_q == 3'd4) && (echo_q == wreg_q);
    if (state_q != S_SKIP_LINE) begin
      eq_cnt_d = 2'd0;
      ndig_d   = 3'd0;
      echo_d   = 16'h0000;
    end
`else
    echo_ok  = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        // A zero length would wrap the counter through 65536 words.
        if (start) begin
          if (len != 16'd0) begin
            wcnt_d  = len;
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = S_WAIT_L;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_L: begin
        if (rx_valid && (rx_data == PROMPT_LOAD)) state_d = S_SEND_LEN_LO;
      end
      S_SEND_LEN_LO: begin
        if (byte_done) state_d = S_SEND_LEN_HI;
      end
      S_SEND_LEN_HI: begin
        if (byte_done) state_d = S_WAIT_EQ;
      end
      S_WAIT_EQ: begin
        if (rx_valid && (rx_data == PROMPT_WORD)) begin
          wreg_d  = img_data;
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (byte_done) state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (byte_done) state_d = S_SKIP_LINE;
      end
      S_SKIP_LINE: begin
        if (rx_valid) begin
          if (rx_data == EOL_CHAR) begin
            wcnt_d = wcnt_q - 16'd1;
            addr_d = addr_q + 1'b1;
            if (!echo_ok) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else if (wcnt_q == 16'd1) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_EQ;
            end
          end
`ifdef TG_SENDER_ECHO_CHECK_EN
          // The request '=' consumed in WAIT_EQ was the first; digits follow the second.
          else if (rx_data == PROMPT_WORD) begin
            if (eq_cnt_q != 2'd2) eq_cnt_d = eq_cnt_q + 2'd1;
          end else if ((eq_cnt_q == 2'd1) && (ndig_q != 3'd4) && is_hex(rx_data)) begin
            echo_d = {echo_q[11:0], hex_nibble(rx_data)};
            ndig_d = ndig_q + 3'd1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requests follow the next state so the first byte loads one cycle after 'L'.
  assign byte_req = is_send_state(state_d);

  always_comb begin
    byte_dat = 8'h00;
    case (state_d)
      S_SEND_LEN_LO: byte_dat = wcnt_q[7:0];
      S_SEND_LEN_HI: byte_dat = wcnt_q[15:8];
      S_SEND_LO:     byte_dat = wreg_d[7:0];
      S_SEND_HI:     byte_dat = wreg_q[15:8];
      default:       byte_dat = 8'h00;
    endcase
  end

  tg_tx_handshake u_txh (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_req_i  (byte_req),
    .byte_dat_i  (byte_dat),
    .byte_done_o (byte_done),
    .tx_data_o   (tx_data),
    .tx_load_o   (tx_load),
    .tx_busy_i   (tx_busy)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign img_addr = addr_q;

endmodule

// File: tb/tb_tg_image_sender.sv
// Self-checking bench for tg_image_sender: ROM, UART transmitter and visor
// models drive the design against an expected byte stream built per session.
module tb_tg_image_sender;

`ifdef TG_SENDER_ECHO_CHECK_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] len;
  logic        busy, done, err;
  logic [15:0] img_addr;
  logic [15:0] img_data;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          busy_hold = 2;
  int          dly_max = 2;
  bit          chk_en = 1'b1;
  logic [7:0]  tx_q[$];
  logic [15:0] mem[0:255];
  logic [7:0]  addr_lat;

  always #5 clk = ~clk;

  tg_image_sender dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .img_addr (img_addr),
    .img_data (img_data),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  // Synchronous ROM: data follows the address with one cycle of lag.
  initial begin
    img_data = 16'h0000;
    addr_lat = 8'h00;
    forever begin
      @(negedge clk);
      img_data = mem[addr_lat];
      addr_lat = img_addr[7:0];
    end
  end

  // UART transmitter: random accept delay, then busy for busy_hold cycles.
  initial begin
    logic [7:0] first;
    int         d, h;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_load === 1'b1 && reset_n === 1'b1) begin
        first = tx_data;
        d = $urandom_range(0, dly_max);
        repeat (d) @(negedge clk);
        if (chk_en) begin
          n_chk++;
          if (tx_load !== 1'b1 || tx_data !== first)
            $display("FAIL txh_req_hold: load=%b data=%h, required load=1 data=%h", tx_load, tx_data, first);
          else n_pass++;
        end
        tx_q.push_back(tx_data);
        tx_busy = 1'b1;
        h = busy_hold;
        for (int i = 0; i < h; i++) begin
          @(negedge clk);
          if (chk_en && (i == 0 || i == h - 1)) begin
            n_chk++;
            if (tx_load !== 1'b0 || tx_data !== first)
              $display("FAIL txh_ack_hold: load=%b data=%h, required load=0 data=%h", tx_load, tx_data, first);
            else n_pass++;
          end
        end
        tx_busy = 1'b0;
      end
    end
  end

  // Pulse monitor; busy must already be low in the done cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL done_busy: busy=%b with done, required 0", busy);
        else n_pass++;
      end
      if (err === 1'b1) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? ({4'h0, n} + 8'h30) : ({4'h0, n} + 8'h57);
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_hex4(input logic [15:0] v);
    for (int k = 3; k >= 0; k--) send_rx(hexc(v[4*k +: 4]));
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while ((tx_q.size() < n || tx_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 3000) $display("FAIL wait_tx: got %0d bytes, required %0d", tx_q.size(), n);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_session(input int n, input bit extra_eq, input bit bad_echo);
    logic [7:0]  exp_q[$];
    logic [15:0] echo_w, wv;
    int          d0, e0;
    bit          exp_err;
    tx_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    exp_err = bad_echo && ECHO_EN;
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    @(negedge clk);
    len = n[15:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 16'($urandom);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL sess_busy: busy=%b, required 1", busy);
    else n_pass++;
    start = 1'b1;
    len = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    send_rx(8'h3D);
    send_rx(8'h41);
    @(negedge clk);
    rx_data  = 8'h4C;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    n_chk++;
    if (tx_load !== 1'b1) $display("FAIL load_latency: tx_load=%b one cycle after L, required 1", tx_load);
    else n_pass++;
    wait_tx(2);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back(mem[w][7:0]);
      exp_q.push_back(mem[w][15:8]);
      wv = w[15:0];
      send_rx(8'h41);
      send_hex4(wv);
      send_rx(8'h3D);
      if (extra_eq) send_rx(8'h3D);
      wait_tx(4 + 2 * w);
      echo_w = (bad_echo && w == n - 1) ? (mem[w] ^ 16'h0001) : mem[w];
      send_hex4(mem[w]);
      send_rx(8'h3D);
      send_hex4(echo_w);
      if (extra_eq) begin
        send_rx(8'h3D);
        send_rx(8'h3D);
      end
      send_rx(8'h0D);
      send_rx(8'h0A);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (tx_q.size() != exp_q.size()) $display("FAIL tx_count: %0d bytes, required %0d", tx_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i])
        $display("FAIL tx_byte[%0d]: %h, required %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if ((done_cnt - d0) != (exp_err ? 0 : 1)) $display("FAIL done_count: %0d pulses, required %0d", done_cnt - d0, exp_err ? 0 : 1);
    else n_pass++;
    n_chk++;
    if ((err_cnt - e0) != (exp_err ? 1 : 0)) $display("FAIL err_count: %0d pulses, required %0d", err_cnt - e0, exp_err ? 1 : 0);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL end_busy: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    len      = 16'h0000;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: %b, required 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done: %b, required 0", done); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rst_err: %b, required 0", err); else n_pass++;
    n_chk++; if (tx_load !== 1'b0) $display("FAIL rst_tx_load: %b, required 0", tx_load); else n_pass++;
    n_chk++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: %h, required 00", tx_data); else n_pass++;
    n_chk++; if (img_addr !== 16'h0000) $display("FAIL rst_img_addr: %h, required 0000", img_addr); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_zero();
    int e0;
    bit seen;
    e0 = err_cnt;
    seen = 1'b0;
    @(negedge clk);
    len = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (err !== 1'b1) $display("FAIL len0_err: %b, required 1", err); else n_pass++;
    @(negedge clk);
    n_chk++; if (err !== 1'b0) $display("FAIL len0_err_width: %b one cycle later, required 0", err); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || tx_load !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (seen) $display("FAIL len0_idle: busy or tx_load rose, required both 0"); else n_pass++;
    n_chk++; if ((err_cnt - e0) != 1) $display("FAIL len0_err_count: %0d, required 1", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_basic();
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    run_session(2, 1'b0, 1'b0);
  endtask

  task automatic test_slow_busy();
    busy_hold = 50;
    dly_max = 4;
    mem[0] = 16'($urandom);
    mem[1] = 16'($urandom);
    run_session(2, 1'b0, 1'b0);
    busy_hold = 2;
    dly_max = 2;
  endtask

  task automatic test_extra_eq();
    for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
    run_session(3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      busy_hold = $urandom_range(2, 4);
      run_session($urandom_range(1, 5), 1'($urandom), 1'b0);
    end
    busy_hold = 2;
  endtask

  task automatic test_reset_mid();
    int d0, e0, t;
    tx_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    busy_hold = 10;
    @(negedge clk);
    len = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_rx(8'h4C);
    wait_tx(2);
    send_rx(8'h3D);
    t = 0;
    while (tx_q.size() < 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    n_chk++; if (tx_load !== 1'b0) $display("FAIL mid_rst_tx_load: %b, required 0", tx_load); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: %b, required 0", busy); else n_pass++;
    n_chk++; if (tx_data !== 8'h00) $display("FAIL mid_rst_tx_data: %h, required 00", tx_data); else n_pass++;
    n_chk++; if (img_addr !== 16'h0000) $display("FAIL mid_rst_img_addr: %h, required 0000", img_addr); else n_pass++;
    n_chk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL mid_rst_pulses: done=%b err=%b, required 0 0", done, err); else n_pass++;
    reset_n = 1'b1;
    t = 0;
    while (tx_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    n_chk++;
    if (done_cnt != d0 || err_cnt != e0) $display("FAIL mid_rst_no_pulse: done+%0d err+%0d, required 0 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    busy_hold = 2;
    mem[0] = 16'($urandom);
    run_session(1, 1'b0, 1'b0);
  endtask

  task automatic test_echo();
    mem[0] = 16'h1234;
    run_session(1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_basic();
    test_slow_busy();
    test_extra_eq();
    test_random();
    test_reset_mid();
    test_echo();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
